// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_ctrl
//  Brief    : RV32I instruction fetch sequencer. Owns the PC, addresses a
//             combinational-read instruction memory and registers each
//             fetched word with its PC into a one-entry valid/ready stage.
//             Handles redirect/flush, misaligned and out-of-range faults,
//             and halting on an all-zero memory word.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [31:0]       IMEM_DATA,
  output logic [31:0]       INST,
  output logic [31:0]       PC_OUT,
  output logic              INST_VALID,
  input  logic              INST_READY,
  input  logic              REDIRECT,
  input  logic [31:0]       REDIRECT_PC,
  output logic              HALTED,
  output logic              FAULT,
  output logic [31:0]       FAULT_PC
);

  // Memory depth as a 32-bit quantity for comparison against PC[31:2].
  localparam logic [31:0] C_DEPTH = 32'(IMEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic        r_halted;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  state_t      w_state_nx;
  logic [31:0] w_pc_nx;
  logic [31:0] w_inst_nx;
  logic [31:0] w_pc_out_nx;
  logic        w_valid_nx;
  logic        w_halted_nx;
  logic        w_fault_nx;
  logic [31:0] w_fault_pc_nx;

  logic        w_slot_free;
  logic        w_pc_oor;
  logic        w_redir_misaligned;
  logic        w_word_zero;

  // The output slot can take a new word when empty or being drained now.
  assign w_slot_free        = !r_valid || INST_READY;
  // Range check uses the full word index so a wrapped PC can never alias
  // back into memory.
  assign w_pc_oor           = ({2'b00, r_pc[31:2]} >= C_DEPTH);
  assign w_redir_misaligned = (REDIRECT_PC[1:0] != 2'b00);
  assign w_word_zero        = (IMEM_DATA == 32'h0000_0000);

  assign IMEM_ADDR  = r_pc[ADDR_W+1:2];
  assign INST       = r_inst;
  assign PC_OUT     = r_pc_out;
  assign INST_VALID = r_valid;
  assign HALTED     = r_halted;
  assign FAULT      = r_fault;
  assign FAULT_PC   = r_fault_pc;

  // Next-state and datapath update: redirect first, then enable/idle
  // handling, then the fetch load point with range check before zero check.
  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_inst_nx     = r_inst;
    w_pc_out_nx   = r_pc_out;
    w_valid_nx    = r_valid;
    w_halted_nx   = r_halted;
    w_fault_nx    = r_fault;
    w_fault_pc_nx = r_fault_pc;

    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (REDIRECT) begin
          // Flush; any handshake in this cycle has already completed.
          w_valid_nx = 1'b0;
          if (w_redir_misaligned) begin
            w_fault_nx    = 1'b1;
            w_fault_pc_nx = REDIRECT_PC;
            w_state_nx    = ST_FAULT;
          end else begin
            w_pc_nx    = REDIRECT_PC;
            w_state_nx = EN ? ST_RUN : ST_IDLE;
          end
        end else if ((r_state == ST_IDLE) || !EN) begin
          // No fetch while idle or while leaving RUN; the held entry may
          // still be consumed by decode.
          if (r_valid && INST_READY) begin
            w_valid_nx = 1'b0;
          end
          w_state_nx = EN ? ST_RUN : ST_IDLE;
        end else if (w_slot_free) begin
          if (w_pc_oor) begin
            w_fault_nx    = 1'b1;
            w_fault_pc_nx = r_pc;
            w_valid_nx    = 1'b0;
            w_state_nx    = ST_FAULT;
          end else if (w_word_zero) begin
            w_halted_nx = 1'b1;
            w_valid_nx  = 1'b0;
            w_state_nx  = ST_HALT;
          end else begin
            w_inst_nx   = IMEM_DATA;
            w_pc_out_nx = r_pc;
            w_valid_nx  = 1'b1;
            w_pc_nx     = r_pc + 32'd4;
          end
        end
        // Otherwise stalled: everything holds.
      end
      default: begin
        // Terminal states: nothing deliverable, inputs ignored.
        w_valid_nx = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // PC, output stage and sticky status registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc       <= RESET_PC;
      r_inst     <= 32'h0;
      r_pc_out   <= 32'h0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else begin
      r_pc       <= w_pc_nx;
      r_inst     <= w_inst_nx;
      r_pc_out   <= w_pc_out_nx;
      r_valid    <= w_valid_nx;
      r_halted   <= w_halted_nx;
      r_fault    <= w_fault_nx;
      r_fault_pc <= w_fault_pc_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_ctrl
//  Brief    : Self-checking bench for inst_fetch_ctrl: vector table, directed
//             corner sequences and randomized episodes against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_ctrl #(
    .IMEM_DEPTH(4096),
    .ADDR_W    (12),
    .RESET_PC  (32'h0)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .EN         (en),
    .IMEM_ADDR  (imem_addr),
    .IMEM_DATA  (imem_data),
    .INST       (inst),
    .PC_OUT     (pc_out),
    .INST_VALID (inst_valid),
    .INST_READY (inst_ready),
    .REDIRECT   (redirect),
    .REDIRECT_PC(redirect_pc),
    .HALTED     (halted),
    .FAULT      (fault),
    .FAULT_PC   (fault_pc)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  int          m_mode;
  logic [31:0] m_pc, m_inst, m_pcout, m_fpc;
  logic        m_valid, m_halted, m_fault;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 32'h0; m_inst = 32'h0; m_pcout = 32'h0;
    m_fpc = 32'h0; m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic r, input logic rd, input logic [31:0] rpc);
    int unsigned widx;
    logic [31:0] word;
    if (m_mode == M_HALT || m_mode == M_FAULT) begin
      m_valid = 1'b0;
    end else if (rd) begin
      m_valid = 1'b0;
      if (rpc % 4 != 0) begin
        m_fault = 1'b1; m_fpc = rpc; m_mode = M_FAULT;
      end else begin
        m_pc = rpc; m_mode = e ? M_RUN : M_IDLE;
      end
    end else if (m_mode == M_IDLE || !e) begin
      if (m_valid && r) m_valid = 1'b0;
      m_mode = e ? M_RUN : M_IDLE;
    end else if (!m_valid || r) begin
      widx = m_pc / 4;
      if (widx >= 4096) begin
        m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0; m_mode = M_FAULT;
      end else begin
        word = mem[widx];
        if (word == 32'h0) begin
          m_halted = 1'b1; m_valid = 1'b0; m_mode = M_HALT;
        end else begin
          m_inst = word; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // ------------------------------------------------------------- helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drives one cycle's inputs just after a falling edge, advances the model
  // and returns at the next falling edge with DUT outputs settled.
  task automatic step(input logic e, input logic r, input logic rd, input logic [31:0] rpc);
    en = e; inst_ready = r; redirect = rd; redirect_pc = rpc;
    model_step(e, r, rd, rpc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #2 rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(m_valid));
    chk({tag, ".inst"},  inst,            m_inst);
    chk({tag, ".pcout"}, pc_out,          m_pcout);
    chk({tag, ".addr"},  32'(imem_addr),  32'(m_pc[13:2]));
    chk({tag, ".halt"},  32'(halted),     32'(m_halted));
    chk({tag, ".fault"}, 32'(fault),      32'(m_fault));
    chk({tag, ".fpc"},   fault_pc,        m_fpc);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0] = 32'h0030_0093;
    mem[1] = 32'h0010_8133;
    mem[2] = 32'h4010_01B3;
  endtask

  task automatic load_long();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0013 + (32'(i) << 20);
  endtask

  // ---------------------------------------------------------- vectors
  typedef struct {
    logic        rst_first;
    logic        en;
    logic        rdy;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [11:0] e_addr;
    logic        e_halt;
  } vec_t;

  function automatic vec_t mk(logic rf, logic e, logic r, logic [31:0] ei,
                              logic [31:0] ep, logic ev, logic [11:0] ea, logic eh);
    vec_t v;
    v.rst_first = rf; v.en = e; v.rdy = r; v.e_inst = ei; v.e_pc = ep;
    v.e_valid = ev; v.e_addr = ea; v.e_halt = eh;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    rst = 1'b1; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    load_prog();

    // Consecutive fetch, then halt on word 3.
    vecs[0]  = mk(1, 1, 1, 32'h0,          32'h0, 0, 12'd0, 0);
    vecs[1]  = mk(0, 1, 1, 32'h0030_0093,  32'h0, 1, 12'd1, 0);
    vecs[2]  = mk(0, 1, 1, 32'h0010_8133,  32'h4, 1, 12'd2, 0);
    vecs[3]  = mk(0, 1, 1, 32'h4010_01B3,  32'h8, 1, 12'd3, 0);
    vecs[4]  = mk(0, 1, 1, 32'h4010_01B3,  32'h8, 0, 12'd3, 1);
    // Stall with READY low, then resume.
    vecs[5]  = mk(1, 1, 0, 32'h0,          32'h0, 0, 12'd0, 0);
    vecs[6]  = mk(0, 1, 0, 32'h0030_0093,  32'h0, 1, 12'd1, 0);
    vecs[7]  = mk(0, 1, 0, 32'h0030_0093,  32'h0, 1, 12'd1, 0);
    vecs[8]  = mk(0, 1, 0, 32'h0030_0093,  32'h0, 1, 12'd1, 0);
    vecs[9]  = mk(0, 1, 0, 32'h0030_0093,  32'h0, 1, 12'd1, 0);
    vecs[10] = mk(0, 1, 1, 32'h0010_8133,  32'h4, 1, 12'd2, 0);
    vecs[11] = mk(0, 1, 1, 32'h4010_01B3,  32'h8, 1, 12'd3, 0);
    vecs[12] = mk(0, 1, 1, 32'h4010_01B3,  32'h8, 0, 12'd3, 1);
    vecs[13] = mk(0, 1, 1, 32'h4010_01B3,  32'h8, 0, 12'd3, 1);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(inst_valid), 32'h0);
    chk("rst.inst",  inst,            32'h0);
    chk("rst.pcout", pc_out,          32'h0);
    chk("rst.addr",  32'(imem_addr),  32'h0);
    chk("rst.halt",  32'(halted),     32'h0);
    chk("rst.fault", 32'(fault),      32'h0);
    chk("rst.fpc",   fault_pc,        32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst_first) do_reset();
      step(vecs[i].en, vecs[i].rdy, 1'b0, 32'h0);
      chk($sformatf("vec%0d.valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.inst", i),  inst,            vecs[i].e_inst);
      chk($sformatf("vec%0d.pcout", i), pc_out,          vecs[i].e_pc);
      chk($sformatf("vec%0d.addr", i),  32'(imem_addr),  32'(vecs[i].e_addr));
      chk($sformatf("vec%0d.halt", i),  32'(halted),     32'(vecs[i].e_halt));
    end

    // Redirect with concurrent accept, one bubble, then target fetch.
    load_long();
    do_reset();
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("redir.pre_valid", 32'(inst_valid), 32'h1);
    step(1, 1, 1, 32'h40);
    chk("redir.flush",     32'(inst_valid), 32'h0);
    chk("redir.addr",      32'(imem_addr),  32'd16);
    step(1, 1, 0, 32'h0);
    chk("redir.valid",     32'(inst_valid), 32'h1);
    chk("redir.pcout",     pc_out,          32'h40);
    chk("redir.inst",      inst,            mem[16]);

    // Misaligned redirect faults and is sticky.
    do_reset();
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h42);
    chk("mis.fault", 32'(fault),      32'h1);
    chk("mis.fpc",   fault_pc,        32'h42);
    chk("mis.valid", 32'(inst_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, k[0], ~k[0], 32'h80);
      chk("mis.hold_fault", 32'(fault),      32'h1);
      chk("mis.hold_fpc",   fault_pc,        32'h42);
      chk("mis.hold_valid", 32'(inst_valid), 32'h0);
      chk("mis.hold_addr",  32'(imem_addr),  32'd1);
    end

    // Redirect out of range: fault at the next fetch attempt.
    do_reset();
    step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h4000);
    chk("oor.nofault", 32'(fault), 32'h0);
    step(1, 1, 0, 32'h0);
    chk("oor.fault", 32'(fault),      32'h1);
    chk("oor.fpc",   fault_pc,        32'h4000);
    chk("oor.valid", 32'(inst_valid), 32'h0);
    chk("oor.inst",  inst,            32'h0);

    // Asynchronous reset mid-run.
    do_reset();
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("arst.pre_addr", 32'(imem_addr), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 32'(inst_valid), 32'h0);
    chk("arst.inst",  inst,            32'h0);
    chk("arst.pcout", pc_out,          32'h0);
    chk("arst.addr",  32'(imem_addr),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("arst.refetch_valid", 32'(inst_valid), 32'h1);
    chk("arst.refetch_pc",    pc_out,          32'h0);
    chk("arst.refetch_inst",  inst,            mem[0]);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 20; ep++) begin
      for (int i = 0; i < 4096; i++)
        mem[i] = ($urandom_range(0, 24) == 0) ? 32'h0 : ($urandom | 32'h1);
      do_reset();
      for (int c = 0; c < 60; c++) begin
        logic        e, r, rd;
        logic [31:0] rpc;
        int          sel;
        e   = ($urandom_range(0, 9) != 0);
        r   = ($urandom_range(0, 3) != 0);
        rd  = ($urandom_range(0, 11) == 0);
        sel = $urandom_range(0, 7);
        if (sel == 0)      rpc = 32'($urandom_range(0, 255)) | 32'h1;
        else if (sel == 1) rpc = 32'($urandom_range(4090, 4097)) << 2;
        else               rpc = 32'($urandom_range(0, 63)) << 2;
        step(e, r, rd, rpc);
        chk_model($sformatf("rand%0d.%0d", ep, c));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the RV32I core's instruction memory. Owns the PC, drives the word address into the combinational-read instruction memory, and registers each fetched instruction with its PC into a one-entry output stage. The output stage uses a valid/ready handshake to decode. Also handles branch/jump redirect with flush, misaligned and out-of-range fault detection, and halt on an empty (all-zero) memory word.

Parameters:
IMEM_DEPTH, 4096, instruction memory depth in 32-bit words
ADDR_W, 12, word-address width; equals log2(IMEM_DEPTH)
RESET_PC, 32'h0000_0000, byte PC loaded on reset; must be 4-byte aligned

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
EN  input  1  fetch enable; level-sensitive
IMEM_ADDR  output  ADDR_W  word index to instruction memory; always PC[ADDR_W+1:2]
IMEM_DATA  input  32  instruction word returned combinationally for IMEM_ADDR
INST  output  32  registered instruction
PC_OUT  output  32  byte PC of INST
INST_VALID  output  1  INST/PC_OUT hold a deliverable instruction
INST_READY  input  1  decode accepts INST this cycle
REDIRECT  input  1  branch/jump taken; one-cycle pulse
REDIRECT_PC  input  32  target byte PC
HALTED  output  1  sticky; a zero word was fetched
FAULT  output  1  sticky; misaligned or out-of-range PC
FAULT_PC  output  32  offending PC

Behaviour:
- Reset (async, RST=1):
  - PC=RESET_PC; state IDLE.
  - INST=0, PC_OUT=0, INST_VALID=0, HALTED=0, FAULT=0, FAULT_PC=0.
- States: IDLE, RUN, HALT, FAULT. HALT and FAULT are exited only by reset.
- IDLE:
  - EN=1 -> RUN next cycle; no fetch in the transition cycle.
  - A held valid instruction stays valid until accepted.
- RUN:
  - Definitions: slot_free = !INST_VALID | INST_READY; load = slot_free & !REDIRECT.
  - On load with PC in range and IMEM_DATA != 0: INST<=IMEM_DATA, PC_OUT<=PC, INST_VALID<=1, PC<=PC+4.
  - First instruction appears 1 cycle after entering RUN. Steady-state throughput is 1 instr/cycle when INST_READY=1.
  - slot_free=0 (stall): PC, INST, PC_OUT and INST_VALID hold. IMEM_ADDR stays stable.
  - EN=0 -> IDLE next cycle; no load in that cycle.
- Zero word: on load with IMEM_DATA==0:
  - Nothing is captured; INST_VALID<=0 (the current entry was accepted or was empty).
  - PC holds; HALTED<=1; state HALT.
- Out of range: PC[31:2] >= IMEM_DEPTH at a load point:
  - No capture; FAULT<=1, FAULT_PC<=PC, INST_VALID<=0; state FAULT.
  - Checked before the zero-word check.
- Redirect (any state except HALT/FAULT):
  - Highest priority. PC<=REDIRECT_PC; INST_VALID<=0 (flush); no load that cycle.
  - Fetch from the target occurs the next cycle in RUN, giving 1 bubble.
  - If REDIRECT and INST_READY are both high with INST_VALID=1, the handshake completes (decode consumed INST), then the flush applies.
  - REDIRECT_PC[1:0] != 0 -> FAULT<=1, FAULT_PC<=REDIRECT_PC, PC unchanged, state FAULT.
- HALT/FAULT:
  - INST_VALID=0; inputs ignored.
  - IMEM_ADDR continues to reflect the held PC.
- PC arithmetic: PC+4 is modulo 2^32. The range check traps before any wrap can be fetched.
- Reset mid-operation: all state returns to reset values immediately. A pending instruction is dropped.

Test Plan:
1. Reset, memory words 0..2 = 0x00300093, 0x00108133, 0x401001B3, word 3 = 0, EN=1, INST_READY=1 -> INST 0x00300093/PC 0x0, then 0x00108133/0x4, then 0x401001B3/0x8 on consecutive cycles; then INST_VALID=0, HALTED=1, IMEM_ADDR=3.
2. Same program, INST_READY=0 for 3 cycles after first valid -> INST=0x00300093, PC_OUT=0 held for 3 cycles, IMEM_ADDR=1 stable; resumes with PC_OUT=0x4 the cycle after READY=1.
3. REDIRECT pulse with REDIRECT_PC=0x40 while INST_VALID=1 and INST_READY=1 -> next cycle INST_VALID=0; following cycle PC_OUT=0x40, INST=mem[16].
4. REDIRECT_PC=0x42 -> FAULT=1, FAULT_PC=0x42 next cycle; INST_VALID stays 0; further REDIRECT/EN have no effect until RST.
5. REDIRECT_PC=0x4000 (word 4096) -> next fetch attempt sets FAULT=1, FAULT_PC=0x4000, no capture.
6. Assert RST asynchronously mid-RUN at PC=0x8 -> outputs zero immediately, IMEM_ADDR=0 (RESET_PC); EN=1 after release refetches from 0x0.
